// File: rtl/mostrador_scan_ctrl_pkg.sv
// Shared types, glyph constants and default timing for the display scan controller.
package mostrador_scan_ctrl_pkg;

    localparam int unsigned ScanDivDefault    = 50000;
    localparam int unsigned ViewFramesDefault = 500;

    typedef enum logic {
        VIEW_NIVEL = 1'b0,
        VIEW_REGA  = 1'b1
    } view_state_e;

    typedef enum logic [3:0] {
        CharZero,
        CharOne,
        CharTwo,
        CharThree,
        CharErr,
        CharL,
        CharR,
        CharDash,
        CharBlank
    } char_e;

    // Active-low segments, bit0 = a ... bit6 = g.
    localparam logic [6:0] GlyphZero  = 7'b1000000;
    localparam logic [6:0] GlyphOne   = 7'b1111001;
    localparam logic [6:0] GlyphTwo   = 7'b0100100;
    localparam logic [6:0] GlyphThree = 7'b0110000;
    localparam logic [6:0] GlyphErr   = 7'b0000110;
    localparam logic [6:0] GlyphL     = 7'b1000111;
    localparam logic [6:0] GlyphR     = 7'b0101111;
    localparam logic [6:0] GlyphDash  = 7'b0111111;
    localparam logic [6:0] GlyphBlank = 7'b1111111;

    // Flags frozen for the duration of one frame.
    typedef struct packed {
        logic erro;
        logic nv_critico;
        logic nv_baixo;
        logic nv_medio;
        logic nv_alto;
        logic vs;
        logic bs;
    } snap_t;

    typedef struct packed {
        snap_t flags;
        logic  auto_en;
        logic  sd;
    } sync_t;

    // Level digit: error wins, then the lowest level reported.
    function automatic char_e level_char(snap_t s);
        char_e c;
        if (s.erro)            c = CharErr;
        else if (s.nv_critico) c = CharZero;
        else if (s.nv_baixo)   c = CharOne;
        else if (s.nv_medio)   c = CharTwo;
        else if (s.nv_alto)    c = CharThree;
        else                   c = CharDash;
        return c;
    endfunction

    // Irrigation digit: {vs,bs} read as a binary number.
    function automatic char_e irr_char(snap_t s);
        char_e c;
        case ({s.vs, s.bs})
            2'b00:   c = CharZero;
            2'b01:   c = CharOne;
            2'b10:   c = CharTwo;
            default: c = CharThree;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mostrador_scan_ctrl_if.sv
// Sensor/control inputs and display drive outputs of the scan controller.
interface mostrador_scan_ctrl_if;

    logic       nv_critico;
    logic       nv_baixo;
    logic       nv_medio;
    logic       nv_alto;
    logic       erro;
    logic       bs;
    logic       vs;
    logic       auto_en;
    logic       sd;
    logic [6:0] segs;
    logic [3:0] seg_d;
    logic       view;

    modport master (
        output nv_critico, nv_baixo, nv_medio, nv_alto, erro, bs, vs, auto_en, sd,
        input  segs, seg_d, view
    );

    modport slave (
        input  nv_critico, nv_baixo, nv_medio, nv_alto, erro, bs, vs, auto_en, sd,
        output segs, seg_d, view
    );

endinterface

// File: rtl/mostrador_glyph.sv
// Character code to active-low 7-segment pattern.
module mostrador_glyph
    import mostrador_scan_ctrl_pkg::*;
(
    input  char_e      char_i,
    output logic [6:0] segs_o
);

    // Pure lookup; unknown codes show blank.
    always_comb begin
        segs_o = GlyphBlank;
        case (char_i)
            CharZero:  segs_o = GlyphZero;
            CharOne:   segs_o = GlyphOne;
            CharTwo:   segs_o = GlyphTwo;
            CharThree: segs_o = GlyphThree;
            CharErr:   segs_o = GlyphErr;
            CharL:     segs_o = GlyphL;
            CharR:     segs_o = GlyphR;
            CharDash:  segs_o = GlyphDash;
            default:   segs_o = GlyphBlank;
        endcase
    end

endmodule

// File: rtl/mostrador_scan_ctrl.sv
// Four-digit multiplexed display controller: scans D1..D4, alternates between
// level and irrigation views at frame boundaries, blanks the first cycle of
// every slot to avoid ghosting.
module mostrador_scan_ctrl
    import mostrador_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = ScanDivDefault,
    parameter int unsigned VIEW_FRAMES = ViewFramesDefault
) (
    input logic                  clk,
    input logic                  rst_n,
    mostrador_scan_ctrl_if.slave disp
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned FrmW = (VIEW_FRAMES > 1) ? $clog2(VIEW_FRAMES) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(SCAN_DIV - 1);
    localparam logic [FrmW-1:0] FrmLast  = FrmW'(VIEW_FRAMES - 1);

    sync_t             raw;
    sync_t             sync1_q, sync2_q;
    logic [CntW-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]        dig_q, dig_d;
    view_state_e       state_q, state_d;
    logic [FrmW-1:0]   frm_cnt_q, frm_cnt_d;
    logic              auto_run_q, auto_run_d;
    snap_t             snap_q, snap_d;
    logic              frame_start;
    char_e             char_sel;
    logic [6:0]        glyph_segs;
    logic [6:0]        segs_q, segs_d;
    logic [3:0]        seg_en_q, seg_en_d;

    // Gather the asynchronous inputs into one vector for synchronization.
    always_comb begin
        raw.flags.erro       = disp.erro;
        raw.flags.nv_critico = disp.nv_critico;
        raw.flags.nv_baixo   = disp.nv_baixo;
        raw.flags.nv_medio   = disp.nv_medio;
        raw.flags.nv_alto    = disp.nv_alto;
        raw.flags.vs         = disp.vs;
        raw.flags.bs         = disp.bs;
        raw.auto_en          = disp.auto_en;
        raw.sd               = disp.sd;
    end

    // Two-flop synchronizer for every asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Slot counter and digit index; slot count 0 is the blank cycle.
    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        dig_d      = dig_q;
        if (slot_cnt_q == SlotLast) begin
            slot_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
        end
    end

    assign frame_start = (slot_cnt_q == '0) && (dig_q == 2'd0);

    // View FSM next state: decided only on the frame's blank D1 cycle.
    always_comb begin
        state_d    = state_q;
        frm_cnt_d  = frm_cnt_q;
        auto_run_d = auto_run_q;
        snap_d     = snap_q;
        if (frame_start) begin
            snap_d     = sync2_q.flags;
            auto_run_d = sync2_q.auto_en;
            if (sync2_q.flags.erro) begin
                state_d   = VIEW_NIVEL;
                frm_cnt_d = '0;
            end else if (!sync2_q.auto_en) begin
                state_d   = sync2_q.sd ? VIEW_REGA : VIEW_NIVEL;
                frm_cnt_d = '0;
            end else if (!auto_run_q) begin
                // First automatic frame: the frame just ended was not counted.
                frm_cnt_d = '0;
            end else if (frm_cnt_q == FrmLast) begin
                state_d   = (state_q == VIEW_NIVEL) ? VIEW_REGA : VIEW_NIVEL;
                frm_cnt_d = '0;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // Scan counters, view state and frame snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            dig_q      <= 2'd0;
            state_q    <= VIEW_NIVEL;
            frm_cnt_q  <= '0;
            auto_run_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_q      <= dig_d;
            state_q    <= state_d;
            frm_cnt_q  <= frm_cnt_d;
            auto_run_q <= auto_run_d;
            snap_q     <= snap_d;
        end
    end

    // Character for the digit that will be shown next cycle.
    always_comb begin
        char_sel = CharBlank;
        case (dig_d)
            2'd0:    char_sel = (state_d == VIEW_REGA) ? CharR : CharL;
            2'd3:    char_sel = (state_d == VIEW_REGA) ? irr_char(snap_d) : level_char(snap_d);
            default: char_sel = CharBlank;
        endcase
    end

    mostrador_glyph u_glyph (
        .char_i (char_sel),
        .segs_o (glyph_segs)
    );

    // Output next values are built from next counters so the flops line up with the scan.
    always_comb begin
        segs_d   = glyph_segs;
        seg_en_d = ~(4'b0001 << dig_d);
        if (slot_cnt_d == '0) begin
            segs_d   = GlyphBlank;
            seg_en_d = 4'b1111;
        end
    end

    // Registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segs_q   <= GlyphBlank;
            seg_en_q <= 4'b1111;
        end else begin
            segs_q   <= segs_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign disp.segs  = segs_q;
    assign disp.seg_d = seg_en_q;
    assign disp.view  = (state_q == VIEW_REGA);

endmodule
